gcd_share_arbiter: RTL
======================

// Module: gcd_share_arbiter
// PURPOSE
//  Shares one subtractive GCD engine among NREQ independent requesters.
//  - Round-robin arbiter grants one request at a time.
//  - Embedded FSM sequences the A/B subtract datapath (compare, subtract, load).
//  - Result returns on a valid/ready response channel, tagged with the requester index.
//  Sits between client blocks and a single shared GCD compute resource.
// PARAMETERS
//  WIDTH  8  operand/result width (unsigned)
//  NREQ   4  number of requesters (2..8); IDW = $clog2(NREQ)
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           reset, asynchronous, active-high
//  req        in   NREQ        request[i]; held high until ack[i]
//  opa        in   NREQ*WIDTH  operand A of requester i at [i*WIDTH +: WIDTH]
//  opb        in   NREQ*WIDTH  operand B of requester i, same packing
//  ack        out  NREQ        one-hot, 1-cycle pulse: operands of winner captured
//  rsp_valid  out  1           result available
//  rsp_ready  in   1           consumer accepts result
//  rsp_id     out  IDW         index of requester owning result
//  rsp_gcd    out  WIDTH       GCD result
//  busy       out  1           high in CALC or RESP
// BEHAVIOUR
//  States: IDLE, CALC, RESP (2-bit, registered).
//  Reset: state=IDLE, A=B=0, rsp_valid=0, rsp_id=0, rsp_gcd=0, busy=0, ack=0.
//   last=NREQ-1, so req[0] has top priority after reset.
//  IDLE, cycle T:
//   - If req!=0, winner w = first set bit searching last+1, last+2, ... (mod NREQ).
//   - ack[w]=1 combinationally during T.
//   - At end of T: A<=opa[w], B<=opb[w], id<=w, last<=w; next state CALC.
//   - If req==0: ack=0 and stay in IDLE.
//   - ack is never asserted outside IDLE.
//  CALC, one test per cycle, in priority order:
//   1) A==0 or B==0: rsp_gcd<=A|B, go RESP (gcd(0,x)=x; gcd(0,0)=0).
//   2) A==B: rsp_gcd<=A, go RESP.
//   3) A>B: A<=A-B.
//   4) else: B<=B-A.
//   No underflow is possible; subtraction is WIDTH-bit unsigned.
//  RESP:
//   - rsp_valid=1; rsp_id and rsp_gcd held stable until handshake.
//   - On rsp_valid&&rsp_ready at an edge: rsp_valid<=0, state<=IDLE.
//   - New grants are possible in the following cycle (at most one grant per 2 cycles).
//  Latency: ack in cycle T; if engine needs k subtractions, rsp_valid first high in cycle T+k+2.
//  Requests arriving during CALC/RESP wait; req changes there are ignored.
//  A requester that drops req before ack loses its slot without side effects.
//  rst mid-operation: immediate return to reset values; in-flight result discarded; no rsp.
//  X-free: all outputs driven to defined values in every state.
// TESTING
//  1) req=0001, opa0=12, opb0=18, rsp_ready=1:
//     ack=0001 at T; A,B=(12,6),(6,6); rsp_valid at T+4, rsp_gcd=6, rsp_id=0.
//  2) opa=5, opb=5 on req[2]: rsp_valid at T+2, rsp_gcd=5, rsp_id=2.
//     Repeat with (0,9): result 9 at T+2. Repeat with (0,0): result 0.
//  3) req=1111 held continuously, each requester re-raising after its response:
//     grant order 0,1,2,3,0,...; exactly one ack bit per grant.
//  4) rsp_ready=0 for 5 cycles in RESP:
//     rsp_valid, rsp_id, rsp_gcd stable; no ack meanwhile; IDLE one cycle after ready=1.
//  5) Assert rst 2 cycles into CALC of (255,1):
//     all outputs zero next sample; after release, req[1] alone is granted first.
//  6) Random operand sweep (WIDTH=8, 2k pairs, random rsp_ready):
//     rsp_gcd matches reference GCD; rsp_id matches the issuing requester.

Source files
------------

// File: rtl/gcd_share_arbiter.sv
// One subtractive GCD engine shared by NREQ requesters.
// A round-robin grant is followed by compare/subtract iterations and a tagged valid/ready response.
`timescale 1ns/1ps
module gcd_share_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*WIDTH-1:0] opa_i,
    input  logic [NREQ*WIDTH-1:0] opb_i,
    output logic [NREQ-1:0]       ack_o,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [IDW-1:0]        rsp_id_o,
    output logic [WIDTH-1:0]      rsp_gcd_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   last_q, last_d;

    logic             grant_vld;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   scan_id;
    logic [WIDTH-1:0] opa_arr [NREQ];
    logic [WIDTH-1:0] opb_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign opa_arr[i] = opa_i[i*WIDTH +: WIDTH];
        assign opb_arr[i] = opb_i[i*WIDTH +: WIDTH];
    end

    // Round-robin: scan starting just after the last winner, first set bit wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        scan_id   = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            scan_id = IDW'((32'(last_q) + off) % NREQ);
            if (!grant_vld && req_i[scan_id]) begin
                grant_vld = 1'b1;
                grant_id  = scan_id;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            gcd_q   <= '0;
            id_q    <= '0;
            last_q  <= IDW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gcd_q   <= gcd_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        gcd_d   = gcd_q;
        id_d    = id_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    a_d     = opa_arr[grant_id];
                    b_d     = opb_arr[grant_id];
                    id_d    = grant_id;
                    last_d  = grant_id;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (a_q == '0 || b_q == '0) begin
                    gcd_d   = a_q | b_q;
                    state_d = StResp;
                end else if (a_q == b_q) begin
                    gcd_d   = a_q;
                    state_d = StResp;
                end else if (a_q > b_q) begin
                    a_d = a_q - b_q;
                end else begin
                    b_d = b_q - a_q;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ack_o       = '0;
        rsp_valid_o = 1'b0;
        busy_o      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    ack_o[grant_id] = 1'b1;
                end
            end
            StCalc: busy_o = 1'b1;
            StResp: begin
                busy_o      = 1'b1;
                rsp_valid_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign rsp_id_o  = id_q;
    assign rsp_gcd_o = gcd_q;

endmodule
